// File: rtl/aes_uart_pkg.sv
// Shared constants and types for the UART-fed AES decryption frame loader.
package aes_uart_pkg;
    localparam int         BLK_W    = 128;
    localparam logic [7:0] HDR_KEY  = 8'h4B;
    localparam logic [7:0] HDR_DATA = 8'h44;

    typedef enum logic [2:0] {IDLE, KEY, DATA, SETTLE, HOLD} ld_state_e;
endpackage

// File: rtl/aes_dec_frame_loader_if.sv
// Loader bus: UART RX bytes in, key/ciphertext to the decryptor, plaintext out
// with a valid/ready handshake. master = loader side, slave = surroundings.
interface aes_dec_frame_loader_if;
    import aes_uart_pkg::*;

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [BLK_W-1:0] key_out;
    logic [BLK_W-1:0] cipher_out;
    logic [BLK_W-1:0] dec_data_in;
    logic [BLK_W-1:0] plain_out;
    logic             out_valid;
    logic             out_ready;
    logic             key_loaded;
    logic             busy;
    logic             err;

    modport master (
        input  rx_data, rx_valid, dec_data_in, out_ready,
        output key_out, cipher_out, plain_out, out_valid, key_loaded, busy, err
    );
    modport slave (
        output rx_data, rx_valid, dec_data_in, out_ready,
        input  key_out, cipher_out, plain_out, out_valid, key_loaded, busy, err
    );
endinterface

// File: rtl/aes_shift128.sv
// Byte shift register feeding a 128-bit block, first byte ending up in [127:120].
module aes_shift128
    import aes_uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [7:0]       din,
    output logic [BLK_W-1:0] q
);
    // Only 15 bytes are stored; the incoming byte is appended combinationally
    // so the full block is available on the same cycle as its last byte.
    logic [BLK_W-9:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        sh <= '0;
        else if (shift_en) sh <= {sh[BLK_W-17:0], din};
    end

    assign q = {sh, din};
endmodule

// File: rtl/aes_dec_frame_loader.sv
// Frames UART bytes into key/ciphertext blocks for a combinational AES decryptor,
// waits SETTLE_CYCLES, then offers the plaintext. Optional: AES_LOADER_TIMEOUT_EN.
module aes_dec_frame_loader
    import aes_uart_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes_dec_frame_loader_if.master bus
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("aes_dec_frame_loader: SETTLE_CYCLES must be 1..15, TIMEOUT_CYCLES >= 1");
    end

    ld_state_e        state, state_nxt;
    logic [3:0]       byte_cnt, settle_cnt;
    logic [BLK_W-1:0] key_blk, cipher_blk, key_q, cipher_q, plain_q;
    logic             out_valid_q, key_loaded_q, err_q;
    logic             err_nxt, key_commit, cipher_commit, plain_capture, out_clear;
    logic             in_frame, timeout_hit;

    assign in_frame = (state == KEY) || (state == DATA);

    aes_shift128 u_key_sh (
        .clk(clk), .rst_n(rst_n), .shift_en((state == KEY) && bus.rx_valid),
        .din(bus.rx_data), .q(key_blk)
    );
    aes_shift128 u_cipher_sh (
        .clk(clk), .rst_n(rst_n), .shift_en((state == DATA) && bus.rx_valid),
        .din(bus.rx_data), .q(cipher_blk)
    );

`ifdef AES_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt;

    assign timeout_hit = in_frame && !bus.rx_valid && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       idle_cnt <= '0;
        else if (in_frame && !bus.rx_valid && !timeout_hit) idle_cnt <= idle_cnt + TO_W'(1);
        else                                              idle_cnt <= '0;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        err_nxt       = 1'b0;
        key_commit    = 1'b0;
        cipher_commit = 1'b0;
        plain_capture = 1'b0;
        out_clear     = 1'b0;
        case (state)
            IDLE: if (bus.rx_valid) begin
                if (bus.rx_data == HDR_KEY)                        state_nxt = KEY;
                else if (bus.rx_data == HDR_DATA && key_loaded_q) state_nxt = DATA;
                else                                               err_nxt   = 1'b1;
            end
            KEY: if (bus.rx_valid) begin
                if (byte_cnt == 4'd15) begin
                    key_commit = 1'b1;
                    state_nxt  = IDLE;
                end
            end else if (timeout_hit) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            DATA: if (bus.rx_valid) begin
                if (byte_cnt == 4'd15) begin
                    cipher_commit = 1'b1;
                    state_nxt     = SETTLE;
                end
            end else if (timeout_hit) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            SETTLE: begin
                err_nxt = bus.rx_valid;
                // Capture on the last settle cycle so the register sees the
                // decryptor output after exactly SETTLE_CYCLES stable cycles.
                if (settle_cnt <= 4'd1) begin
                    plain_capture = 1'b1;
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                err_nxt = bus.rx_valid;
                if (out_valid_q && bus.out_ready) begin
                    out_clear = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt     <= '0;
            settle_cnt   <= '0;
            key_q        <= '0;
            cipher_q     <= '0;
            plain_q      <= '0;
            out_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= err_nxt;
            if (in_frame && bus.rx_valid)    byte_cnt <= byte_cnt + 4'd1;
            else if (!in_frame || timeout_hit) byte_cnt <= '0;
            if (key_commit) begin
                key_q        <= key_blk;
                key_loaded_q <= 1'b1;
            end
            if (cipher_commit) begin
                cipher_q   <= cipher_blk;
                settle_cnt <= 4'(SETTLE_CYCLES);
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (plain_capture) begin
                plain_q     <= bus.dec_data_in;
                out_valid_q <= 1'b1;
            end else if (out_clear) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.key_out    = key_q;
    assign bus.cipher_out = cipher_q;
    assign bus.plain_out  = plain_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.key_loaded = key_loaded_q;
    assign bus.busy       = (state == SETTLE) || (state == HOLD);
    assign bus.err        = err_q;
endmodule

// File: doc/aes_dec_frame_loader.md
# aes_dec_frame_loader

Upstream feeder for the combinational AES decryption core. Assembles UART RX bytes into a 128-bit key and 128-bit ciphertext blocks and presents them as registered, stable inputs to the decryptor. Waits a programmable settling interval across the decryptor's long combinational path, then captures the plaintext and offers it downstream with a valid/ready handshake.

## Interface
- SETTLE_CYCLES, 4: cycles between a stable ciphertext and plaintext capture (1..15).
- TIMEOUT_CYCLES, 1000000: inter-byte timeout; used only when AES_LOADER_TIMEOUT_EN is defined.
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_data  input  8  byte from UART RX.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- key_out  output  128  key to the decryptor; registered.
- cipher_out  output  128  ciphertext to the decryptor; registered.
- dec_data_in  input  128  plaintext returned by the decryptor.
- plain_out  output  128  captured plaintext.
- out_valid  output  1  plain_out valid; held until accepted.
- out_ready  input  1  downstream accepts plain_out.
- key_loaded  output  1  a full key has been received since reset.
- busy  output  1  high in SETTLE and HOLD.
- err  output  1  one-cycle pulse on a protocol error.

## Operation
- Framing: header byte, then 16 payload bytes. 0x4B ('K') loads the key; 0x44 ('D') loads ciphertext. The first payload byte goes to [127:120], the last to [7:0].
- States:
  - IDLE
    - 'K' → KEY.
    - 'D' with key_loaded=1 → DATA.
    - 'D' with key_loaded=0 → err, stay IDLE.
    - Any other byte → err, stay IDLE.
  - KEY: shift 16 bytes into the key shadow. On the 16th byte, copy the shadow to key_out, set key_loaded, return to IDLE.
  - DATA: shift 16 bytes. On the 16th byte, copy to cipher_out, load the settle counter with SETTLE_CYCLES, go to SETTLE.
  - SETTLE: decrement the counter each cycle. At zero, capture dec_data_in into plain_out, set out_valid, go to HOLD.
  - HOLD: when out_valid and out_ready are both high, clear out_valid and go to IDLE.
- Byte counter is 4 bits and wraps 15→0 on frame completion. The key shadow is separate, so key_out never changes mid-frame.
- rx_valid in SETTLE or HOLD: byte dropped, err pulse. cipher_out and key_out stay unchanged.
- A new 'K' frame while key_loaded=1 replaces the key. key_out updates only on its 16th byte.
- Only one outstanding block. There is no buffering beyond HOLD.

## Timing
- Reset values: every output is 0 (key_out, cipher_out, plain_out, out_valid, key_loaded, busy, err); state IDLE; counters 0. Reset mid-frame discards partial bytes and clears key_loaded.
- The 16th ciphertext byte strobe at edge N updates cipher_out at N+1 and makes busy=1.
- Plain_out is captured and out_valid rises at N+1+SETTLE_CYCLES.
- Handshake: transfer happens on the edge where out_valid=1 and out_ready=1. out_valid falls the next cycle; busy falls the same cycle.
- out_ready may be high before out_valid; transfer then completes on the first out_valid cycle.
- err is high for exactly one cycle per offending byte.
- Back-to-back frames are supported: a header may arrive on the cycle after leaving HOLD or KEY.

## Configuration
- AES_LOADER_TIMEOUT_EN
  - Defined: in KEY or DATA, an idle counter counts cycles without rx_valid. At TIMEOUT_CYCLES it pulses err, discards the partial frame and returns to IDLE. The counter clears on every rx_valid and in all other states.
  - Undefined: no timeout logic; a partial frame waits indefinitely.

## Structure
- Shared package aes_uart_pkg holds:
  - header constants HDR_KEY=8'h4B and HDR_DATA=8'h44;
  - the state enum (IDLE, KEY, DATA, SETTLE, HOLD);
  - the block width of 128.
- Sub-module aes_shift128: an 8-bit-in, 128-bit-out byte shift register with a shift enable. It is instantiated twice, once for the key shadow and once for the cipher shadow.

## Test plan
- Load the FIPS-197 key 000102…0f, then ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, with out_ready=1 → plain_out=00112233445566778899aabbccddeeff and out_valid high exactly SETTLE_CYCLES+1 cycles after the last byte.
- 'D' frame before any key → err pulse, state stays IDLE, following payload bytes each pulse err, cipher_out stays 0.
- Hold out_ready=0 for 50 cycles and send 3 bytes during HOLD → 3 err pulses, plain_out and out_valid stable. Raising out_ready → out_valid low the next cycle.
- Assert rst_n low after 7 key bytes → all outputs 0 and key_loaded=0. A full key frame afterwards loads correctly.
- Reload the key mid-session with a different key → key_out changes only on the 16th byte, and the next block decrypts with the new key.
- With AES_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 5 ciphertext bytes, then idle for 100 cycles → err pulse, return to IDLE. A full frame afterwards decrypts correctly.
